// File: rtl/updown_pkg.sv
// Shared boundary-mode encodings for the counting primitives and the lab top-levels.
package updown_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_WRAP   = 2'b00;
    localparam mode_t MODE_SAT    = 2'b01;
    localparam mode_t MODE_BOUNCE = 2'b10;
    localparam mode_t MODE_HOLD   = 2'b11;

endpackage

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap, saturate and bounce end-of-range behaviour,
// synchronous load, count enable and a registered terminal-count pulse.
module updown_counter_param
    import updown_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             updown,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_Q = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    if ((WIDTH < 2) || (WIDTH > 32) || (MAX_VAL < 64'd1) ||
        (MAX_VAL > ((64'd1 << WIDTH) - 64'd1))) begin : g_param_check
        $fatal(1, "updown_counter_param: illegal WIDTH/MAX_VAL combination");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             dir_q;
    logic             dir_d;
    logic             tc_q;
    logic             tc_d;
    logic             step_up_s;
    logic             hit_s;
    logic             at_max_s;
    logic             at_min_s;

    // Values above MAX_VAL are unreachable but are treated as the upper bound.
    assign at_max_s  = (count_q >= MAX_Q);
    assign at_min_s  = (count_q == '0);
    assign step_up_s = (mode == MODE_BOUNCE) ? dir_q : updown;
    assign hit_s     = step_up_s ? at_max_s : at_min_s;

    // Next-state decode: load beats enable; every non-stepping cycle clears tc.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_Q) ? MAX_Q : load_val;
            dir_d   = updown;
        end else if (en) begin
            case (mode)
                MODE_WRAP: begin
                    dir_d = updown;
                    tc_d  = hit_s;
                    if (hit_s) begin
                        count_d = updown ? '0 : MAX_Q;
                    end else begin
                        count_d = updown ? (count_q + ONE_Q) : (count_q - ONE_Q);
                    end
                end
                MODE_SAT: begin
                    dir_d = updown;
                    tc_d  = hit_s;
                    if (hit_s) begin
                        count_d = updown ? MAX_Q : '0;
                    end else begin
                        count_d = updown ? (count_q + ONE_Q) : (count_q - ONE_Q);
                    end
                end
                MODE_BOUNCE: begin
                    tc_d = hit_s;
                    if (hit_s) begin
                        dir_d   = ~dir_q;
                        count_d = dir_q ? (MAX_Q - ONE_Q) : ONE_Q;
                    end else begin
                        count_d = dir_q ? (count_q + ONE_Q) : (count_q - ONE_Q);
                    end
                end
                default: begin
                    count_d = count_q;
                    dir_d   = dir_q;
                end
            endcase
        end else begin
            count_d = count_q;
            dir_d   = dir_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            dir_q   <= 1'b1;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
        end
    end

    assign q      = count_q;
    assign dir    = dir_q;
    assign tc     = tc_q;
    assign at_max = at_max_s;
    assign at_min = at_min_s;

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench: four 3-bit counters (MAX_VAL 5, 3, 1, 7) share one stimulus
// stream and are compared every cycle against an arithmetic reference model.
module tb_updown_counter_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       updown;
    logic [1:0] mode;
    logic       load;
    logic [2:0] load_val;

    logic [3:0][2:0] q_w;
    logic [3:0]      dir_w;
    logic [3:0]      tc_w;
    logic [3:0]      amax_w;
    logic [3:0]      amin_w;

    int n_checks;
    int n_fail;

    int mxv  [4] = '{5, 3, 1, 7};
    int mq   [4];
    int mdir [4];
    int mtc  [4];

    logic [6:0] exp_v;
    logic [6:0] obs_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        updown_counter_param #(
            .WIDTH   (3),
            .MAX_VAL ((g == 0) ? 64'd5 : (g == 1) ? 64'd3 : (g == 2) ? 64'd1 : 64'd7)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .updown   (updown),
            .mode     (mode),
            .load     (load),
            .load_val (load_val),
            .q        (q_w[g]),
            .dir      (dir_w[g]),
            .tc       (tc_w[g]),
            .at_max   (amax_w[g]),
            .at_min   (amin_w[g])
        );
    end

    // Reference: what the counter should hold after the coming edge.
    task automatic model_step();
        int up;
        int hit;
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                mq[i] = 0; mdir[i] = 1; mtc[i] = 0;
            end else if (load) begin
                mq[i] = (int'(load_val) > mxv[i]) ? mxv[i] : int'(load_val);
                mdir[i] = int'(updown); mtc[i] = 0;
            end else if (!en || mode == 2'b11) begin
                mtc[i] = 0;
            end else begin
                up  = (mode == 2'b10) ? mdir[i] : int'(updown);
                hit = up ? (mq[i] >= mxv[i]) : (mq[i] == 0);
                mtc[i] = hit;
                if (mode == 2'b10) begin
                    if (hit) begin
                        mdir[i] = 1 - mdir[i];
                        mq[i] = up ? mxv[i] - 1 : 1;
                    end else begin
                        mq[i] = up ? mq[i] + 1 : mq[i] - 1;
                    end
                end else begin
                    mdir[i] = up;
                    if (!hit)              mq[i] = up ? mq[i] + 1 : mq[i] - 1;
                    else if (mode == 2'b00) mq[i] = up ? 0 : mxv[i];
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; mode = 2'b00; en = 1'b1; updown = 1'b1; load = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0; load = 1'b1; load_val = 3'd6;
        tick();
        n_checks++;
        if ({q_w[3], dir_w[3], tc_w[3], amin_w[3], amax_w[3]} !== 7'b000_1_0_1_0) begin
            n_fail++;
            $display("FAIL reset_state: got q=%0d dir=%b tc=%b min=%b max=%b, want 0 1 0 1 0",
                     q_w[3], dir_w[3], tc_w[3], amin_w[3], amax_w[3]);
        end
        for (int i = 0; i < 4; i++) begin
            exp_v = {3'(mq[i]), 1'(mdir[i]), 1'(mtc[i]), mq[i] >= mxv[i], mq[i] == 0};
            obs_v = {q_w[i], dir_w[i], tc_w[i], amax_w[i], amin_w[i]};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset_model inst%0d: got %b, want %b", i, obs_v, exp_v);
            end
        end
        rst_n = 1'b1; load = 1'b0;
    endtask

    task automatic test_wrap();
        int wq  [6] = '{1, 2, 3, 4, 5, 0};
        int wtc [6] = '{0, 0, 0, 0, 0, 1};
        mode = 2'b00; en = 1'b1; updown = 1'b1;
        for (int s = 0; s < 7; s++) begin
            if (s == 6) updown = 1'b0;
            tick();
            n_checks++;
            if (s < 6 && (int'(q_w[0]) != wq[s] || int'(tc_w[0]) != wtc[s])) begin
                n_fail++;
                $display("FAIL wrap_up step%0d: got q=%0d tc=%b, want q=%0d tc=%0d",
                         s, q_w[0], tc_w[0], wq[s], wtc[s]);
            end else if (s == 6 && ({q_w[0], tc_w[0]} !== {3'd5, 1'b1})) begin
                n_fail++;
                $display("FAIL wrap_down: got q=%0d tc=%b, want q=5 tc=1", q_w[0], tc_w[0]);
            end
            for (int i = 0; i < 4; i++) begin
                exp_v = {3'(mq[i]), 1'(mdir[i]), 1'(mtc[i]), mq[i] >= mxv[i], mq[i] == 0};
                obs_v = {q_w[i], dir_w[i], tc_w[i], amax_w[i], amin_w[i]};
                n_checks++;
                if (obs_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL wrap_model inst%0d: got %b, want %b", i, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_sat();
        int sq  [4] = '{5, 5, 5, 4};
        int stc [4] = '{0, 1, 1, 0};
        mode = 2'b01; en = 1'b1; updown = 1'b1; load = 1'b1; load_val = 3'd4;
        tick();
        load = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (s == 3) updown = 1'b0;
            tick();
            n_checks++;
            if (int'(q_w[0]) != sq[s] || int'(tc_w[0]) != stc[s]) begin
                n_fail++;
                $display("FAIL sat step%0d: got q=%0d tc=%b, want q=%0d tc=%0d",
                         s, q_w[0], tc_w[0], sq[s], stc[s]);
            end
            for (int i = 0; i < 4; i++) begin
                exp_v = {3'(mq[i]), 1'(mdir[i]), 1'(mtc[i]), mq[i] >= mxv[i], mq[i] == 0};
                obs_v = {q_w[i], dir_w[i], tc_w[i], amax_w[i], amin_w[i]};
                n_checks++;
                if (obs_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL sat_model inst%0d: got %b, want %b", i, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int bq  [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
        int btc [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; mode = 2'b10; en = 1'b1;
        for (int s = 0; s < 8; s++) begin
            updown = 1'($urandom_range(1, 0));
            tick();
            n_checks++;
            if (int'(q_w[1]) != bq[s] || int'(tc_w[1]) != btc[s]) begin
                n_fail++;
                $display("FAIL bounce3 step%0d: got q=%0d tc=%b, want q=%0d tc=%0d",
                         s, q_w[1], tc_w[1], bq[s], btc[s]);
            end
            n_checks++;
            if (int'(q_w[2]) != ((s % 2 == 0) ? 1 : 0) || int'(tc_w[2]) != ((s == 0) ? 0 : 1)) begin
                n_fail++;
                $display("FAIL bounce1 step%0d: got q=%0d tc=%b", s, q_w[2], tc_w[2]);
            end
            for (int i = 0; i < 4; i++) begin
                exp_v = {3'(mq[i]), 1'(mdir[i]), 1'(mtc[i]), mq[i] >= mxv[i], mq[i] == 0};
                obs_v = {q_w[i], dir_w[i], tc_w[i], amax_w[i], amin_w[i]};
                n_checks++;
                if (obs_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL bounce_model inst%0d: got %b, want %b", i, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_hold();
        int hq [6] = '{3, 2, 2, 2, 2, 1};
        for (int s = 0; s < 6; s++) begin
            mode = (s >= 2 && s <= 4) ? 2'b11 : 2'b10;
            tick();
            n_checks++;
            if (int'(q_w[1]) != hq[s] || (s >= 1 && dir_w[1] !== 1'b0)) begin
                n_fail++;
                $display("FAIL hold step%0d: got q=%0d dir=%b, want q=%0d dir=0",
                         s, q_w[1], dir_w[1], hq[s]);
            end
            for (int i = 0; i < 4; i++) begin
                exp_v = {3'(mq[i]), 1'(mdir[i]), 1'(mtc[i]), mq[i] >= mxv[i], mq[i] == 0};
                obs_v = {q_w[i], dir_w[i], tc_w[i], amax_w[i], amin_w[i]};
                n_checks++;
                if (obs_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL hold_model inst%0d: got %b, want %b", i, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_load();
        logic ud;
        ud = 1'($urandom_range(1, 0));
        mode = 2'b00; en = 1'b1; updown = ud; load = 1'b1; load_val = 3'd7;
        for (int s = 0; s < 5; s++) begin
            tick();
            load = 1'b0; en = 1'b0;
            n_checks++;
            if ({q_w[0], dir_w[0], tc_w[0], amax_w[0]} !== {3'd5, ud, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL load_clamp step%0d: got q=%0d dir=%b tc=%b max=%b, want q=5 dir=%b tc=0 max=1",
                         s, q_w[0], dir_w[0], tc_w[0], amax_w[0], ud);
            end
            for (int i = 0; i < 4; i++) begin
                exp_v = {3'(mq[i]), 1'(mdir[i]), 1'(mtc[i]), mq[i] >= mxv[i], mq[i] == 0};
                obs_v = {q_w[i], dir_w[i], tc_w[i], amax_w[i], amin_w[i]};
                n_checks++;
                if (obs_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL load_model inst%0d: got %b, want %b", i, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 600; s++) begin
            rst_n    = ($urandom_range(31, 0) != 0);
            load     = ($urandom_range(7, 0) == 0);
            en       = ($urandom_range(3, 0) != 0);
            updown   = ($urandom_range(3, 0) != 0) ? updown : ~updown;
            mode     = ($urandom_range(15, 0) == 0) ? 2'($urandom_range(3, 0)) : mode;
            load_val = 3'($urandom_range(7, 0));
            tick();
            for (int i = 0; i < 4; i++) begin
                exp_v = {3'(mq[i]), 1'(mdir[i]), 1'(mtc[i]), mq[i] >= mxv[i], mq[i] == 0};
                obs_v = {q_w[i], dir_w[i], tc_w[i], amax_w[i], amin_w[i]};
                n_checks++;
                if (obs_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL random cyc%0d inst%0d: got %b, want %b", s, i, obs_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; en = 1'b0; updown = 1'b1; mode = 2'b00; load = 1'b0; load_val = 3'd0;
        tick();
        tick();
        test_reset();
        test_wrap();
        test_sat();
        test_bounce();
        test_hold();
        test_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
